// File: rtl/fetcher_if.sv
// Fetch-unit bus bundle.
// Groups the request/acknowledge handshake, the ROM nibble bus and the
// assembled-instruction result into one interface.
//   pc_in          12  start address of the instruction (sequencer -> fetcher)
//   fetch_start     1  fetch request (sequencer -> fetcher)
//   fetch_done_ack  1  consumer acknowledge (decoder -> fetcher)
//   inst_data_in    4  ROM nibble at pc_out (ROM -> fetcher)
//   inst_len        3  instruction length in bytes, 2 = two bytes (sequencer -> fetcher)
//   rom_select      1  ROM enable (fetcher -> ROM)
//   pc_out         12  current ROM nibble address (fetcher -> ROM)
//   fetch_done      1  instruction valid (fetcher -> decoder)
//   inst_out       16  assembled, left-justified instruction (fetcher -> decoder)
// The slave modport is the fetcher's view; the master modport is the
// view of the surrounding core (sequencer, ROM and decoder together).
interface fetcher_if;
  logic [11:0] pc_in;
  logic        fetch_start;
  logic        fetch_done_ack;
  logic [3:0]  inst_data_in;
  logic [2:0]  inst_len;
  logic        rom_select;
  logic [11:0] pc_out;
  logic        fetch_done;
  logic [15:0] inst_out;

  modport slave (
    input  pc_in,
    input  fetch_start,
    input  fetch_done_ack,
    input  inst_data_in,
    input  inst_len,
    output rom_select,
    output pc_out,
    output fetch_done,
    output inst_out
  );

  modport master (
    output pc_in,
    output fetch_start,
    output fetch_done_ack,
    output inst_data_in,
    output inst_len,
    input  rom_select,
    input  pc_out,
    input  fetch_done,
    input  inst_out
  );
endinterface

// File: rtl/fetcher.sv
// Instruction fetch unit for the 4-bit CPU core.
// Reads a 1- or 2-byte instruction from program ROM one nibble per clock,
// starting at pc_in, assembles it left-justified into a 16-bit word and
// presents it to the decoder under a done/ack handshake.
// Ports:
//   clk    1  system clock, rising edge
//   reset  1  asynchronous active-high reset
//   bus       fetcher_if.slave (see fetcher_if.sv for the signal list)
// All outputs are registers or direct state decodes; no input reaches an
// output combinationally.
module fetcher (
  input  logic     clk,
  input  logic     reset,
  fetcher_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  idx;
  logic [2:0]  n_total;
  logic [11:0] pc;
  logic [15:0] inst;
  logic        last_nib;

  // Drop one nibble into the instruction word; nibble 0 lands in [15:12].
  function automatic logic [15:0] insert_nibble(input logic [15:0] word,
                                                input logic [1:0]  pos,
                                                input logic [3:0]  nib);
    logic [15:0] res;
    res = word;
    case (pos)
      2'd0:    res[15:12] = nib;
      2'd1:    res[11:8]  = nib;
      2'd2:    res[7:4]   = nib;
      default: res[3:0]   = nib;
    endcase
    return res;
  endfunction

  // The nibble being captured this cycle is the final one of the fetch.
  assign last_nib = ({1'b0, idx} == (n_total - 3'd1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.fetch_start)    state_nxt = FETCH;
      FETCH:   if (last_nib)           state_nxt = DONE;
      // A request arriving together with the ack is dropped on purpose:
      // the sequencer must re-issue it once we are back in IDLE.
      DONE:    if (bus.fetch_done_ack) state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx     <= 2'd0;
      n_total <= 3'd2;
      pc      <= 12'h000;
      inst    <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (bus.fetch_start) begin
            pc      <= bus.pc_in;
            idx     <= 2'd0;
            inst    <= 16'h0000;
            n_total <= (bus.inst_len == 3'd2) ? 3'd4 : 3'd2;
          end
        end
        FETCH: begin
          inst <= insert_nibble(inst, idx, bus.inst_data_in);
          pc   <= pc + 12'd1;   // 12-bit wrap from FFF to 000 is intended
          idx  <= idx + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.rom_select = (state == FETCH);
  assign bus.fetch_done = (state == DONE);
  assign bus.pc_out     = pc;
  assign bus.inst_out   = inst;

endmodule

// File: tb/tb_fetcher.sv
// Testbench for fetcher: directed fetches against a ROM image, checked
// every cycle against a transaction-level model plus literal expectations.
module tb_fetcher;

  logic clk;
  logic reset;
  logic cmp_en;
  int   checks;
  int   passes;

  logic [3:0] rom [4096];

  fetcher_if bus ();

  fetcher dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.inst_data_in = rom[bus.pc_out];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level model: the start address, how many nibbles have
  // been taken so far, and the word built from the ROM image.
  logic        m_active = 1'b0;
  logic        m_done   = 1'b0;
  logic [11:0] m_start  = 12'h000;
  int          m_got    = 0;
  int          m_n      = 2;
  logic [15:0] m_inst   = 16'h0000;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_start  <= 12'h000;
      m_got    <= 0;
      m_n      <= 2;
      m_inst   <= 16'h0000;
    end else if (m_done) begin
      if (bus.fetch_done_ack) m_done <= 1'b0;
    end else if (m_active) begin
      m_inst <= m_inst | ({rom[12'(m_start + 12'(m_got))], 12'h000} >> (4 * m_got));
      m_got  <= m_got + 1;
      if (m_got + 1 == m_n) begin
        m_active <= 1'b0;
        m_done   <= 1'b1;
      end
    end else if (bus.fetch_start) begin
      m_active <= 1'b1;
      m_start  <= bus.pc_in;
      m_got    <= 0;
      m_n      <= (bus.inst_len == 3'd2) ? 4 : 2;
      m_inst   <= 16'h0000;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model rom_select", 32'(bus.rom_select), 32'(m_active));
      chk("model fetch_done", 32'(bus.fetch_done), 32'(m_done));
      chk("model pc_out", 32'(bus.pc_out), 32'(12'(m_start + 12'(m_got))));
      chk("model inst_out", 32'(bus.inst_out), 32'(m_inst));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while (!bus.fetch_done && k < 12) begin
      step();
      k++;
    end
    chk(nm, 32'(bus.fetch_done), 32'd1);
  endtask

  task automatic ack();
    bus.fetch_done_ack = 1'b1;
    step();
    bus.fetch_done_ack = 1'b0;
  endtask

  task automatic start(input logic [11:0] pc, input logic [2:0] len);
    bus.pc_in       = pc;
    bus.inst_len    = len;
    bus.fetch_start = 1'b1;
    step();
    bus.fetch_start = 1'b0;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    cmp_en = 1'b0;
    reset  = 1'b1;
    bus.pc_in          = 12'h000;
    bus.fetch_start    = 1'b0;
    bus.fetch_done_ack = 1'b0;
    bus.inst_len       = 3'd0;
    for (int i = 0; i < 4096; i++) rom[i] = 4'h0;
    rom[12'hDEA] = 4'hA; rom[12'hDEB] = 4'h5;
    rom[12'hABC] = 4'h3; rom[12'hABD] = 4'hC; rom[12'hABE] = 4'h7; rom[12'hABF] = 4'hE;
    rom[12'hFFF] = 4'h1; rom[12'h000] = 4'h2; rom[12'h001] = 4'h3; rom[12'h002] = 4'h4;
    rom[12'h100] = 4'h9; rom[12'h101] = 4'h8; rom[12'h102] = 4'h7; rom[12'h103] = 4'h6;
    rom[12'h200] = 4'hF; rom[12'h201] = 4'h0;

    @(posedge clk);
    cmp_en = 1'b1;
    step();
    reset = 1'b0;
    chk("reset pc_out", 32'(bus.pc_out), 32'h000);
    chk("reset inst_out", 32'(bus.inst_out), 32'h0000);
    chk("reset fetch_done", 32'(bus.fetch_done), 32'd0);

    // One-byte fetch
    chk("1B rom_select before E0", 32'(bus.rom_select), 32'd0);
    start(12'hDEA, 3'd1);
    chk("1B rom_select after E0", 32'(bus.rom_select), 32'd1);
    chk("1B pc after E0", 32'(bus.pc_out), 32'hDEA);
    step();
    chk("1B pc after E1", 32'(bus.pc_out), 32'hDEB);
    step();
    chk("1B done after E2", 32'(bus.fetch_done), 32'd1);
    chk("1B inst", 32'(bus.inst_out), 32'hA500);
    chk("1B final pc", 32'(bus.pc_out), 32'hDEC);
    ack();
    chk("1B done after ack", 32'(bus.fetch_done), 32'd0);

    // Two-byte fetch with a stray request mid-fetch
    start(12'hABC, 3'd2);
    chk("2B pc E0", 32'(bus.pc_out), 32'hABC);
    bus.pc_in = 12'h123; bus.inst_len = 3'd1; bus.fetch_start = 1'b1;
    step();
    bus.fetch_start = 1'b0;
    chk("2B pc E1", 32'(bus.pc_out), 32'hABD);
    step();
    chk("2B pc E2", 32'(bus.pc_out), 32'hABE);
    step();
    chk("2B pc E3", 32'(bus.pc_out), 32'hABF);
    chk("2B rom_select E3", 32'(bus.rom_select), 32'd1);
    step();
    chk("2B done E4", 32'(bus.fetch_done), 32'd1);
    chk("2B inst", 32'(bus.inst_out), 32'h3C7E);
    chk("2B final pc", 32'(bus.pc_out), 32'hAC0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold done", 32'(bus.fetch_done), 32'd1);
      chk("hold inst", 32'(bus.inst_out), 32'h3C7E);
    end
    // Request in the ack cycle must be dropped
    bus.fetch_done_ack = 1'b1; bus.fetch_start = 1'b1; bus.pc_in = 12'h555;
    step();
    bus.fetch_done_ack = 1'b0; bus.fetch_start = 1'b0;
    chk("ack-cycle start done", 32'(bus.fetch_done), 32'd0);
    chk("ack-cycle start rom_select", 32'(bus.rom_select), 32'd0);
    step();
    chk("ack-cycle start no restart", 32'(bus.rom_select), 32'd0);
    chk("idle holds pc", 32'(bus.pc_out), 32'hAC0);

    // Address wrap-around
    start(12'hFFF, 3'd2);
    chk("wrap pc E0", 32'(bus.pc_out), 32'hFFF);
    step();
    chk("wrap pc E1", 32'(bus.pc_out), 32'h000);
    wait_done("wrap done");
    chk("wrap inst", 32'(bus.inst_out), 32'h1234);
    chk("wrap final pc", 32'(bus.pc_out), 32'h003);
    ack();

    // Asynchronous reset after the second nibble of a two-byte fetch
    start(12'h100, 3'd2);
    step();
    step();
    #3 reset = 1'b1;
    #1;
    chk("rst rom_select", 32'(bus.rom_select), 32'd0);
    chk("rst pc_out", 32'(bus.pc_out), 32'h000);
    chk("rst inst_out", 32'(bus.inst_out), 32'h0000);
    chk("rst fetch_done", 32'(bus.fetch_done), 32'd0);
    step();
    reset = 1'b0;
    step();
    chk("post-rst no done", 32'(bus.fetch_done), 32'd0);

    // One-byte fetch after reset; length 3 also means one byte
    start(12'h200, 3'd3);
    wait_done("post-rst done");
    chk("post-rst inst", 32'(bus.inst_out), 32'hF000);
    chk("post-rst pc", 32'(bus.pc_out), 32'h202);
    ack();
    step();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
